counter_sweep_ctrl: RTL and testbench

Sequencer that drives one `loaded_counter` instance through programmed sweeps. A sweep loads a start value and steps by a fixed increment for a set number of steps, either one way or out-and-back. Each counter value is presented to a downstream consumer on a valid/ready stream. The block sits between a register/config interface and address- or sample-generating datapaths that need deterministic value sequences.

---
 rtl/counter_sweep_ctrl_pkg.sv | 15 +
 rtl/counter_sweep_ctrl_loaded_counter.sv | 35 +++
 rtl/counter_sweep_ctrl.sv | 142 ++++++++++++++
 tb/tb_counter_sweep_ctrl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/counter_sweep_ctrl_pkg.sv
// Shared definitions for the counter sweep sequencer: FSM state encodings
// and counting direction constants.
package counter_sweep_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic UP   = 1'b1;
    localparam logic DOWN = 1'b0;

endpackage : counter_sweep_ctrl_pkg

// File: rtl/counter_sweep_ctrl_loaded_counter.sv
// Loadable up/down counter with a programmable increment; arithmetic wraps
// modulo 2^WIDTH.
module loaded_counter
    import counter_sweep_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_enable,
    input  logic [WIDTH-1:0] load_value,
    input  logic             enable,
    input  logic             up,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load_enable) begin
            count_q <= load_value;
        end else if (enable) begin
            case (up)
                UP:   count_q <= count_q + step;
                DOWN: count_q <= count_q - step;
            endcase
        end
    end

    assign count = count_q;

endmodule : loaded_counter

// File: rtl/counter_sweep_ctrl.sv
// Sweep sequencer: loads a start value into loaded_counter and streams the
// stepped values (single pass or out-and-back) over a valid/ready interface.
module counter_sweep_ctrl
    import counter_sweep_ctrl_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = 8,
    parameter int unsigned STEPS_WIDTH   = 16
) (
    input  logic                     clk_i,
    input  logic                     s_rst_n_i,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic [COUNTER_WIDTH-1:0] start_value_i,
    input  logic [COUNTER_WIDTH-1:0] step_i,
    input  logic [STEPS_WIDTH-1:0]   step_count_i,
    input  logic                     direction_i,
    input  logic                     bounce_i,
    input  logic                     ready_i,
    output logic [COUNTER_WIDTH-1:0] value_o,
    output logic                     valid_o,
    output logic                     busy_o,
    output logic                     done_o
);

    state_t                   state_q, state_d;
    logic [COUNTER_WIDTH-1:0] start_value_q;
    logic [COUNTER_WIDTH-1:0] step_q;
    logic [STEPS_WIDTH-1:0]   step_count_q;
    logic                     dir_q;
    logic                     bounce_q;
    logic [STEPS_WIDTH-1:0]   remaining_q, remaining_d;
    logic                     pass_q, pass_d;
    logic                     valid_q, busy_q, done_q;
    logic                     load_en_c, step_en_c, step_up_c;
    logic                     accept_c;

    assign accept_c = (state_q == IDLE) && start_i;

    // State, sweep progress and registered stream/status outputs
    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            pass_q      <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            pass_q      <= pass_d;
            valid_q     <= (state_d == RUN);
            busy_q      <= (state_d != IDLE);
            done_q      <= (state_d == DONE);
        end
    end

    // Sweep configuration captured on an accepted start
    always_ff @(posedge clk_i) begin
        if (!s_rst_n_i) begin
            start_value_q <= '0;
            step_q        <= '0;
            step_count_q  <= '0;
            dir_q         <= UP;
            bounce_q      <= 1'b0;
        end else if (accept_c) begin
            start_value_q <= start_value_i;
            step_q        <= step_i;
            step_count_q  <= step_count_i;
            dir_q         <= direction_i;
            bounce_q      <= bounce_i;
        end
    end

    // Next-state and counter control
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        pass_d      = pass_q;
        load_en_c   = 1'b0;
        step_en_c   = 1'b0;
        step_up_c   = pass_q ? ~dir_q : dir_q;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d     = LOAD;
                    remaining_d = step_count_i;
                    pass_d      = 1'b0;
                end
            end
            LOAD: begin
                load_en_c = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                if (ready_i) begin
                    if (remaining_q != '0) begin
                        step_en_c   = 1'b1;
                        remaining_d = remaining_q - STEPS_WIDTH'(1);
                    end else if (bounce_q && !pass_q && (step_count_q != '0)) begin
                        // Turning beat already showed the peak, so the reverse step is taken now
                        pass_d      = 1'b1;
                        step_en_c   = 1'b1;
                        step_up_c   = ~dir_q;
                        remaining_d = step_count_q - STEPS_WIDTH'(1);
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (stop_i && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    loaded_counter #(
        .WIDTH (COUNTER_WIDTH)
    ) u_counter (
        .clk         (clk_i),
        .rst_n       (s_rst_n_i),
        .load_enable (load_en_c),
        .load_value  (start_value_q),
        .enable      (step_en_c),
        .up          (step_up_c),
        .step        (step_q),
        .count       (value_o)
    );

    assign valid_o = valid_q;
    assign busy_o  = busy_q;
    assign done_o  = done_q;

endmodule : counter_sweep_ctrl

// File: tb/tb_counter_sweep_ctrl.sv
// Directed bench for counter_sweep_ctrl with hand-computed beat sequences.
module tb_counter_sweep_ctrl;

    logic        clk;
    logic        s_rst_n;
    logic        start;
    logic        stop;
    logic [7:0]  start_value;
    logic [7:0]  step;
    logic [15:0] step_count;
    logic        direction;
    logic        bounce;
    logic        ready;
    logic [7:0]  value;
    logic        valid;
    logic        busy;
    logic        done;

    int checks   = 0;
    int failures = 0;

    counter_sweep_ctrl #(
        .COUNTER_WIDTH (8),
        .STEPS_WIDTH   (16)
    ) dut (
        .clk_i         (clk),
        .s_rst_n_i     (s_rst_n),
        .start_i       (start),
        .stop_i        (stop),
        .start_value_i (start_value),
        .step_i        (step),
        .step_count_i  (step_count),
        .direction_i   (direction),
        .bounce_i      (bounce),
        .ready_i       (ready),
        .value_o       (value),
        .valid_o       (valid),
        .busy_o        (busy),
        .done_o        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "bench timed out");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic start_sweep(input logic [7:0] sv, input logic [7:0] st,
                               input logic [15:0] n, input logic dir, input logic bnc);
        start_value = sv;
        step        = st;
        step_count  = n;
        direction   = dir;
        bounce      = bnc;
        start       = 1'b1;
        tick();
        start       = 1'b0;
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_valid", 32'(valid), 32'd0);
        tick();
    endtask

    task automatic expect_sweep(input string tag, input int unsigned exp_vals[$]);
        foreach (exp_vals[i]) begin
            chk({tag, "_valid"}, 32'(valid), 32'd1);
            chk({tag, "_value"}, 32'(value), exp_vals[i]);
            tick();
        end
        chk({tag, "_end_valid"}, 32'(valid), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd1);
        chk({tag, "_done_busy"}, 32'(busy), 32'd1);
        tick();
        chk({tag, "_done_clear"}, 32'(done), 32'd0);
        chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
    endtask

    initial begin
        s_rst_n     = 1'b0;
        start       = 1'b0;
        stop        = 1'b0;
        start_value = '0;
        step        = '0;
        step_count  = '0;
        direction   = 1'b1;
        bounce      = 1'b0;
        ready       = 1'b1;
        tick();
        tick();
        chk("rst_value", 32'(value), 32'd0);
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        s_rst_n = 1'b1;
        tick();

        // Up, single pass
        start_sweep(8'd10, 8'd3, 16'd4, 1'b1, 1'b0);
        expect_sweep("up_single", '{10, 13, 16, 19, 22});

        // Bounce with wrap-around
        start_sweep(8'd250, 8'd4, 16'd2, 1'b1, 1'b1);
        expect_sweep("bounce_wrap", '{250, 254, 2, 254, 250});

        // Backpressure, down count, with a start pulse while busy
        start_sweep(8'd100, 8'd5, 16'd3, 1'b0, 1'b0);
        ready = 1'b1;
        chk("bp_v0", 32'(value), 32'd100);
        tick();
        ready = 1'b0;
        chk("bp_v1", 32'(value), 32'd95);
        start_value = 8'd200;
        step        = 8'd1;
        start       = 1'b1;
        tick();
        start = 1'b0;
        chk("bp_stall_valid", 32'(valid), 32'd1);
        chk("bp_stall_value", 32'(value), 32'd95);
        tick();
        ready = 1'b1;
        chk("bp_resume_value", 32'(value), 32'd95);
        tick();
        expect_sweep("bp_tail", '{90, 85});

        // N = 0 in both modes
        start_sweep(8'd77, 8'd9, 16'd0, 1'b1, 1'b0);
        expect_sweep("n0_single", '{77});
        start_sweep(8'd33, 8'd9, 16'd0, 1'b0, 1'b1);
        expect_sweep("n0_bounce", '{33});

        // Stop during the third beat
        start_sweep(8'd0, 8'd1, 16'd10, 1'b1, 1'b0);
        chk("stop_v0", 32'(value), 32'd0);
        tick();
        chk("stop_v1", 32'(value), 32'd1);
        tick();
        chk("stop_v2", 32'(value), 32'd2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_valid", 32'(valid), 32'd0);
        chk("stop_busy", 32'(busy), 32'd0);
        chk("stop_done", 32'(done), 32'd0);
        tick();
        chk("stop_done_later", 32'(done), 32'd0);
        chk("stop_busy_later", 32'(busy), 32'd0);

        // Reset mid-RUN, then a full sweep
        start_sweep(8'd40, 8'd2, 16'd5, 1'b1, 1'b0);
        chk("rr_v0", 32'(value), 32'd40);
        tick();
        chk("rr_v1", 32'(value), 32'd42);
        s_rst_n = 1'b0;
        tick();
        chk("rr_value", 32'(value), 32'd0);
        chk("rr_valid", 32'(valid), 32'd0);
        chk("rr_busy", 32'(busy), 32'd0);
        chk("rr_done", 32'(done), 32'd0);
        s_rst_n = 1'b1;
        tick();
        start_sweep(8'd40, 8'd2, 16'd5, 1'b1, 1'b0);
        expect_sweep("rr_full", '{40, 42, 44, 46, 48, 50});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_counter_sweep_ctrl
